maze_wall_engine: RTL and testbench
===================================

Name: maze_wall_engine

Overview:
Parametrised maze wall block. Holds a runtime-loadable table of NUM_WALLS axis-aligned wall rectangles. Drives a registered pixel-enable for the VGA colour mux. Runs a sequential collision scan against the ball on request, returning stop_right/left/up/down. Sits between the VGA timing counters, the ball/cursor position logic and the pixel mux.

Parameters:
NUM_WALLS, 32, number of wall table entries
COORD_W, 11, width of screen coordinates
BW_W, 5, width of ball_width
IDX_W, $clog2(NUM_WALLS), wall index width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  write one wall table entry this cycle
wr_idx  in  IDX_W  entry to write
wr_valid  in  1  1 = wall present, 0 = delete entry
wr_x0, wr_x1, wr_y0, wr_y1  in  COORD_W each  wall bounds (exclusive)
hcounter, vcounter  in  COORD_W  current pixel
enable  out  1  pixel lies inside any valid wall (registered)
x_ball, y_ball  in  COORD_W  ball top-left
ball_width  in  BW_W  ball side length
chk_start  in  1  request a collision scan
chk_busy  out  1  scan in progress
chk_done  out  1  one-cycle pulse: stop flags updated
stop_right, stop_left, stop_up, stop_down  out  1 each  collision result, held until the next chk_done

Behaviour:
- Reset: enable, chk_busy, chk_done and all stop_* = 0. FSM = IDLE. Table cleared to all-invalid (see Optional Feature).
- Table: registered. A write takes effect at the next edge. The last write wins.
- Pixel hit for wall i: valid_i && x0<h<x1 && y0<v<y1, strict on all sides. enable = OR over all walls, registered, so latency is 1 cycle.
- Arithmetic: all sums and differences use COORD_W+2 signed intermediates. No underflow wrap, including when bw > y0.
- Collision terms for wall i (bw = ball_width):
  - yov = (y_ball+bw > y0) && (y_ball < y1-1)
  - xov = (x_ball+bw > x0) && (x_ball < x1-1)
  - right: x_ball+bw == x0 && yov
  - left: x_ball == x1-1 && yov
  - down: y_ball+bw == y0 && xov
  - up: y_ball == y1-1 && xov
- FSM states: IDLE, SCAN, DONE.
  - IDLE: when chk_start=1, latch x_ball, y_ball, ball_width; clear the four accumulators; set idx=0; go to SCAN.
  - SCAN: chk_busy=1. Evaluate entry idx against the latched ball position and OR the result into the accumulators; invalid entries contribute 0. If idx==NUM_WALLS-1, go to DONE; otherwise idx++.
  - DONE: copy accumulators to stop_*, chk_done=1 for this cycle, go to IDLE.
- Timing: if chk_start is sampled at edge k, chk_busy is high from k+1 through k+NUM_WALLS. chk_done is high, and stop_* are new, in the cycle after edge k+NUM_WALLS+1.
- chk_start while not IDLE is ignored and is not queued. chk_start during DONE is also ignored.
- Ball inputs changing mid-scan have no effect, because they are latched.
- A write during SCAN to an entry not yet scanned is seen. A write to an already-scanned entry or the current entry is not seen this scan.
- A wall whose bounds give an empty interior (x1<=x0+1 or y1<=y0+1) never sets enable. Its collision terms are evaluated as written.
- rst mid-scan: abort, go to IDLE, clear outputs. chk_done is not pulsed.

Optional Feature:
MAZE_DEFAULT_LAYOUT_EN
- Defined: reset loads the package constant DEFAULT_LAYOUT into entries 0..25 as valid. The remaining entries are invalid. The first maze is visible with no loader.
- Undefined: all entries are invalid after reset, and the layout is supplied only via the write port.

Decomposition:
- Package maze_pkg:
  - wall_t struct {valid, x0, x1, y0, y1}.
  - Default parameter values.
  - DEFAULT_LAYOUT array of 26 wall_t.
  - FSM state enum.
- One sub-module, maze_wall_collide: combinational evaluation of one wall_t against a ball, returning the 4 stop bits. The FSM instantiates it once on the indexed entry.

Test Plan:
1. Write entry 0 = {1,482,492,46,82}; drive h=487,v=60 → enable=1 one cycle later. Drive h=482,v=60 → enable=0 (edge exclusive).
2. Entry 0 as in test 1, bw=10, x_ball=472, y_ball=50, pulse chk_start → chk_done after NUM_WALLS+1 cycles (33) with stop_right=1 and the other stop_* = 0. Repeat with x_ball=491 → stop_left=1.
3. Entry 1 = {1,449,459,20,46}, bw=31, y_ball=0, x_ball=418 → stop_right=1 (no underflow on 20-31). Then x_ball=450, y_ball=45 → stop_up=1.
4. chk_start pulsed again on cycle 5 of a scan → ignored: a single chk_done, and chk_busy never deasserts early.
5. Mid-scan, write entry 31 = wall that blocks stop_down → result reflects it. Write to entry 0 mid-scan → not reflected until the next scan.
6. Assert rst at scan cycle 10 → chk_busy=0, all stop_*=0, no chk_done. With MAZE_DEFAULT_LAYOUT_EN, h=487,v=60 → enable=1 after reset with no writes. Without the macro → enable=0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze wall engine.
// MAZE_DEFAULT_LAYOUT_EN selects whether DEFAULT_LAYOUT is loaded at reset.
package maze_pkg;

    localparam int NUM_WALLS_DEF = 32;
    localparam int COORD_W_DEF   = 11;
    localparam int BW_W_DEF      = 5;
    localparam int LAYOUT_LEN    = 26;

    // Bounds are exclusive: the interior is x0 < h < x1, y0 < v < y1.
    typedef struct packed {
        logic                   valid;
        logic [COORD_W_DEF-1:0] x0;
        logic [COORD_W_DEF-1:0] x1;
        logic [COORD_W_DEF-1:0] y0;
        logic [COORD_W_DEF-1:0] y1;
    } wall_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    localparam wall_t DEFAULT_LAYOUT [LAYOUT_LEN] = '{
        '{1'b1, 11'd482, 11'd492, 11'd46,  11'd82 },
        '{1'b1, 11'd449, 11'd459, 11'd20,  11'd46 },
        '{1'b1, 11'd0,   11'd640, 11'd0,   11'd11 },
        '{1'b1, 11'd0,   11'd640, 11'd469, 11'd480},
        '{1'b1, 11'd0,   11'd11,  11'd0,   11'd480},
        '{1'b1, 11'd629, 11'd640, 11'd0,   11'd480},
        '{1'b1, 11'd40,  11'd200, 11'd60,  11'd70 },
        '{1'b1, 11'd100, 11'd110, 11'd70,  11'd200},
        '{1'b1, 11'd200, 11'd300, 11'd150, 11'd160},
        '{1'b1, 11'd290, 11'd300, 11'd160, 11'd260},
        '{1'b1, 11'd50,  11'd150, 11'd250, 11'd260},
        '{1'b1, 11'd150, 11'd160, 11'd260, 11'd400},
        '{1'b1, 11'd220, 11'd380, 11'd330, 11'd340},
        '{1'b1, 11'd370, 11'd380, 11'd200, 11'd330},
        '{1'b1, 11'd400, 11'd560, 11'd120, 11'd130},
        '{1'b1, 11'd550, 11'd560, 11'd130, 11'd250},
        '{1'b1, 11'd440, 11'd450, 11'd200, 11'd380},
        '{1'b1, 11'd450, 11'd600, 11'd300, 11'd310},
        '{1'b1, 11'd500, 11'd510, 11'd380, 11'd469},
        '{1'b1, 11'd60,  11'd70,  11'd300, 11'd440},
        '{1'b1, 11'd70,  11'd140, 11'd430, 11'd440},
        '{1'b1, 11'd240, 11'd250, 11'd380, 11'd469},
        '{1'b1, 11'd300, 11'd420, 11'd400, 11'd410},
        '{1'b1, 11'd580, 11'd629, 11'd180, 11'd190},
        '{1'b1, 11'd320, 11'd330, 11'd40,  11'd120},
        '{1'b1, 11'd200, 11'd210, 11'd11,  11'd90 }
    };

endpackage

// File: rtl/maze_wall_collide.sv
// Combinational contact test of one wall against the ball; all sums are
// widened and signed so a ball wider than the wall's offset cannot wrap.
module maze_wall_collide
    import maze_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int BW_W    = BW_W_DEF
)(
    input  wall_t              wall,
    input  logic [COORD_W-1:0] x_ball,
    input  logic [COORD_W-1:0] y_ball,
    input  logic [BW_W-1:0]    ball_width,
    output logic               stop_right,
    output logic               stop_left,
    output logic               stop_up,
    output logic               stop_down
);

    localparam int SW = COORD_W + 2;

    logic signed [SW-1:0] xb, yb, bw, x0, x1, y0, y1;
    logic signed [SW-1:0] x_end, y_end, x_last, y_last;
    logic                 xov, yov;

    assign xb = $signed(SW'(x_ball));
    assign yb = $signed(SW'(y_ball));
    assign bw = $signed(SW'(ball_width));
    assign x0 = $signed(SW'(wall.x0));
    assign x1 = $signed(SW'(wall.x1));
    assign y0 = $signed(SW'(wall.y0));
    assign y1 = $signed(SW'(wall.y1));

    assign x_end  = xb + bw;
    assign y_end  = yb + bw;
    assign x_last = x1 - SW'(1);
    assign y_last = y1 - SW'(1);

    assign yov = (y_end > y0) && (yb < y_last);
    assign xov = (x_end > x0) && (xb < x_last);

    assign stop_right = wall.valid && (x_end == x0) && yov;
    assign stop_left  = wall.valid && (xb == x_last) && yov;
    assign stop_down  = wall.valid && (y_end == y0) && xov;
    assign stop_up    = wall.valid && (yb == y_last) && xov;

endmodule

// File: rtl/maze_wall_engine.sv
// Wall table with registered pixel enable and a one-entry-per-cycle collision scan.
// Define MAZE_DEFAULT_LAYOUT_EN to preload DEFAULT_LAYOUT into the table at reset.
module maze_wall_engine
    import maze_pkg::*;
#(
    parameter int NUM_WALLS = NUM_WALLS_DEF,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int BW_W      = BW_W_DEF,
    parameter int IDX_W     = $clog2(NUM_WALLS)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic               wr_valid,
    input  logic [COORD_W-1:0] wr_x0,
    input  logic [COORD_W-1:0] wr_x1,
    input  logic [COORD_W-1:0] wr_y0,
    input  logic [COORD_W-1:0] wr_y1,
    input  logic [COORD_W-1:0] hcounter,
    input  logic [COORD_W-1:0] vcounter,
    output logic               enable,
    input  logic [COORD_W-1:0] x_ball,
    input  logic [COORD_W-1:0] y_ball,
    input  logic [BW_W-1:0]    ball_width,
    input  logic               chk_start,
    output logic               chk_busy,
    output logic               chk_done,
    output logic               stop_right,
    output logic               stop_left,
    output logic               stop_up,
    output logic               stop_down
);

    wall_t              wall_tab [NUM_WALLS];
    scan_state_e        state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [COORD_W-1:0] x_lat, y_lat;
    logic [BW_W-1:0]    bw_lat;
    logic [3:0]         acc, hit4;
    logic               start_scan, publish, hit_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WALLS; i++)
                wall_tab[i] <= '0;
`ifdef MAZE_DEFAULT_LAYOUT_EN
            for (int i = 0; i < LAYOUT_LEN; i++)
                wall_tab[i] <= DEFAULT_LAYOUT[i];
`endif
        end else if (wr_en) begin
            wall_tab[wr_idx] <= '{wr_valid, wr_x0, wr_x1, wr_y0, wr_y1};
        end
    end

    always_comb begin
        hit_any = 1'b0;
        for (int i = 0; i < NUM_WALLS; i++)
            if (wall_tab[i].valid &&
                hcounter > wall_tab[i].x0 && hcounter < wall_tab[i].x1 &&
                vcounter > wall_tab[i].y0 && vcounter < wall_tab[i].y1)
                hit_any = 1'b1;
    end

    // Pixel stage: one cycle from counters to enable
    always_ff @(posedge clk) begin
        if (rst) enable <= 1'b0;
        else     enable <= hit_any;
    end

    maze_wall_collide #(.COORD_W(COORD_W), .BW_W(BW_W)) u_collide (
        .wall       (wall_tab[idx]),
        .x_ball     (x_lat),
        .y_ball     (y_lat),
        .ball_width (bw_lat),
        .stop_right (hit4[3]),
        .stop_left  (hit4[2]),
        .stop_up    (hit4[1]),
        .stop_down  (hit4[0])
    );

    always_comb begin
        state_nxt  = state;
        chk_busy   = 1'b0;
        start_scan = 1'b0;
        publish    = 1'b0;
        case (state)
            IDLE: if (chk_start) begin
                start_scan = 1'b1;
                state_nxt  = SCAN;
            end
            SCAN: begin
                chk_busy = 1'b1;
                if (idx == IDX_W'(NUM_WALLS - 1)) state_nxt = DONE;
            end
            DONE: begin
                publish   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            chk_done <= 1'b0;
            {stop_right, stop_left, stop_up, stop_down} <= 4'b0;
        end else begin
            state    <= state_nxt;
            chk_done <= publish;
            if (start_scan)    idx <= '0;
            else if (chk_busy) idx <= idx + 1'b1;
            if (publish) {stop_right, stop_left, stop_up, stop_down} <= acc;
        end
    end

    // Scan datapath: ball snapshot and running OR of contact bits
    always_ff @(posedge clk) begin
        if (start_scan) begin
            x_lat  <= x_ball;
            y_lat  <= y_ball;
            bw_lat <= ball_width;
            acc    <= 4'b0;
        end else if (chk_busy) begin
            acc <= acc | hit4;
        end
    end

endmodule

// File: tb/tb_maze_wall_engine.sv
// Randomised bench for maze_wall_engine against a list-of-rectangles model.
`timescale 1ns/1ps
module tb_maze_wall_engine;
    import maze_pkg::*;

    localparam int NW  = 32;
    localparam int CW  = 11;
    localparam int BWW = 5;
    localparam int IW  = 5;

    typedef struct { bit v; int x0; int x1; int y0; int y1; } mwall_t;

    logic clk = 1'b0;
    logic rst, wr_en, wr_valid, chk_start;
    logic [IW-1:0]  wr_idx;
    logic [CW-1:0]  wr_x0, wr_x1, wr_y0, wr_y1, hcounter, vcounter, x_ball, y_ball;
    logic [BWW-1:0] ball_width;
    logic enable, chk_busy, chk_done, stop_right, stop_left, stop_up, stop_down;

    mwall_t mtab [NW];
    mwall_t snap [NW];
    mwall_t none_w = '{0, 0, 0, 0, 0};
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    maze_wall_engine #(.NUM_WALLS(NW), .COORD_W(CW), .BW_W(BWW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
        .wr_x0(wr_x0), .wr_x1(wr_x1), .wr_y0(wr_y0), .wr_y1(wr_y1),
        .hcounter(hcounter), .vcounter(vcounter), .enable(enable),
        .x_ball(x_ball), .y_ball(y_ball), .ball_width(ball_width),
        .chk_start(chk_start), .chk_busy(chk_busy), .chk_done(chk_done),
        .stop_right(stop_right), .stop_left(stop_left), .stop_up(stop_up), .stop_down(stop_down)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] cur_stops();
        return {stop_right, stop_left, stop_up, stop_down};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) mtab[i] = '{0, 0, 0, 0, 0};
`ifdef MAZE_DEFAULT_LAYOUT_EN
        for (int i = 0; i < LAYOUT_LEN; i++)
            mtab[i] = '{1, int'(DEFAULT_LAYOUT[i].x0), int'(DEFAULT_LAYOUT[i].x1),
                        int'(DEFAULT_LAYOUT[i].y0), int'(DEFAULT_LAYOUT[i].y1)};
`endif
    endtask

    // A pixel is lit when it is strictly inside any valid rectangle.
    function automatic bit model_hit(input int h, input int vc);
        for (int i = 0; i < NW; i++)
            if (mtab[i].v && h > mtab[i].x0 && h < mtab[i].x1 && vc > mtab[i].y0 && vc < mtab[i].y1)
                return 1'b1;
        return 1'b0;
    endfunction

    // Contact rules over the table as the scan sees it, in plain integer arithmetic.
    function automatic logic [3:0] model_stops(input int xb, input int yb, input int bw);
        logic [3:0] r = 4'b0;
        for (int i = 0; i < NW; i++) begin
            bit yov, xov;
            if (!snap[i].v) continue;
            yov = (yb + bw > snap[i].y0) && (yb < snap[i].y1 - 1);
            xov = (xb + bw > snap[i].x0) && (xb < snap[i].x1 - 1);
            if (xb + bw == snap[i].x0 && yov) r[3] = 1'b1;
            if (xb == snap[i].x1 - 1 && yov)  r[2] = 1'b1;
            if (yb == snap[i].y1 - 1 && xov)  r[1] = 1'b1;
            if (yb + bw == snap[i].y0 && xov) r[0] = 1'b1;
        end
        return r;
    endfunction

    task automatic drive_wr(input int idx, input mwall_t w);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_valid = w.v;
        wr_x0 = CW'(w.x0); wr_x1 = CW'(w.x1); wr_y0 = CW'(w.y0); wr_y1 = CW'(w.y1);
    endtask

    task automatic write_wall(input int idx, input mwall_t w);
        drive_wr(idx, w);
        tick();
        wr_en = 1'b0;
        mtab[idx] = w;
    endtask

    task automatic chk_en(input string tag, input int h, input int vc);
        hcounter = CW'(h);
        vcounter = CW'(vc);
        tick();
        check(tag, {31'b0, enable}, {31'b0, model_hit(h, vc)});
    endtask

    // Sample n is taken just after edge k+n, where k is the edge that accepted chk_start.
    task automatic do_scan(input string tag, input int xb, input int yb, input int bw,
                           input int inj_c, input int inj_idx, input mwall_t inj_w,
                           input int restart_c, input int rst_c);
        int busy_cnt = 0;
        int dones    = 0;
        int done_at  = -1;
        logic [3:0] exp_st = 4'b0;
        x_ball = CW'(xb); y_ball = CW'(yb); ball_width = BWW'(bw);
        chk_start = 1'b1;
        snap = mtab;
        tick();
        chk_start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n == rst_c) begin
                chk_start = 1'b0; wr_en = 1'b0; rst = 1'b1;
                tick();
                rst = 1'b0;
                model_reset();
                check({tag, "_rst_busy"}, {31'b0, chk_busy}, 0);
                check({tag, "_rst_stops"}, {28'b0, cur_stops()}, 0);
                for (int m = 0; m < 40; m++) begin
                    if (chk_done || chk_busy) dones++;
                    tick();
                end
                check({tag, "_rst_quiet"}, dones, 0);
                return;
            end
            if (chk_busy) busy_cnt++;
            if (chk_done) begin
                dones++;
                if (done_at < 0) begin
                    done_at = n;
                    exp_st = model_stops(xb, yb, bw);
                    check({tag, "_stops"}, {28'b0, cur_stops()}, {28'b0, exp_st});
                end
            end
            x_ball = CW'($urandom); y_ball = CW'($urandom); ball_width = BWW'($urandom);
            chk_start = (n + 1 == restart_c) || (n + 1 == NW + 1);
            wr_en = 1'b0;
            if (n + 1 == inj_c) begin
                drive_wr(inj_idx, inj_w);
                mtab[inj_idx] = inj_w;
                if (inj_idx >= inj_c) snap[inj_idx] = inj_w;
            end
            tick();
        end
        chk_start = 1'b0;
        wr_en = 1'b0;
        check({tag, "_busy_cycles"}, busy_cnt, NW);
        check({tag, "_done_latency"}, done_at, NW + 1);
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_stops_held"}, {28'b0, cur_stops()}, {28'b0, exp_st});
    endtask

    function automatic int clampc(input int c);
        if (c < 0) return 0;
        if (c > 2047) return 2047;
        return c;
    endfunction

    task automatic rand_scan(input string tag, input int j);
        mwall_t w = mtab[j];
        int bw = int'($urandom_range(1, 31));
        int off = int'($urandom_range(0, bw - 1));
        int xb, yb;
        case ($urandom_range(0, 3))
            0: begin xb = w.x0 - bw;  yb = w.y0 - off; end
            1: begin xb = w.x1 - 1;   yb = w.y0 - off; end
            2: begin yb = w.y1 - 1;   xb = w.x0 - off; end
            default: begin yb = w.y0 - bw; xb = w.x0 - off; end
        endcase
        do_scan(tag, clampc(xb), clampc(yb), bw, -1, 0, none_w, -1, -1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mwall_t w;
        rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_valid = 1'b0;
        wr_x0 = '0; wr_x1 = '0; wr_y0 = '0; wr_y1 = '0;
        hcounter = '0; vcounter = '0; x_ball = '0; y_ball = '0; ball_width = '0;
        chk_start = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset_enable", {31'b0, enable}, 0);
        check("reset_busy", {31'b0, chk_busy}, 0);
        check("reset_done", {31'b0, chk_done}, 0);
        check("reset_stops", {28'b0, cur_stops()}, 0);
        rst = 1'b0;
        tick();
        chk_en("reset_layout_enable", 487, 60);

        write_wall(0, '{1, 482, 492, 46, 82});
        chk_en("t1_inside", 487, 60);
        chk_en("t1_left_edge", 482, 60);
        chk_en("t1_top_edge", 487, 46);

        do_scan("t2_right", 472, 50, 10, -1, 0, none_w, -1, -1);
        do_scan("t2_left", 491, 50, 10, -1, 0, none_w, -1, -1);

        write_wall(1, '{1, 449, 459, 20, 46});
        do_scan("t3_right_wide", 418, 0, 31, -1, 0, none_w, -1, -1);
        do_scan("t3_up", 450, 45, 31, -1, 0, none_w, -1, -1);

        do_scan("t4_restart", 472, 50, 10, -1, 0, none_w, 5, -1);

        do_scan("t5_late_write", 300, 600, 20, 5, 31, '{1, 290, 330, 620, 640}, -1, -1);
        do_scan("t5_early_write", 300, 600, 20, 5, 0, '{1, 290, 330, 580, 601}, -1, -1);
        do_scan("t5_next_scan", 300, 600, 20, -1, 0, none_w, -1, -1);

        for (int r = 0; r < 6; r++) begin
            int j;
            for (int k = 0; k < 8; k++) begin
                w.v  = ($urandom_range(0, 3) != 0);
                w.x0 = int'($urandom_range(0, 1800));
                w.x1 = w.x0 + int'($urandom_range(0, 200));
                w.y0 = int'($urandom_range(0, 1000));
                w.y1 = w.y0 + int'($urandom_range(0, 200));
                write_wall(int'($urandom_range(0, NW - 1)), w);
            end
            for (int k = 0; k < 8; k++) begin
                j = int'($urandom_range(0, NW - 1));
                if (k[0])
                    chk_en("rnd_enable", int'($urandom_range(0, 2047)), int'($urandom_range(0, 1300)));
                else
                    chk_en("rnd_enable_near",
                           mtab[j].x0 + int'($urandom_range(0, mtab[j].x1 - mtab[j].x0)),
                           mtab[j].y0 + int'($urandom_range(0, mtab[j].y1 - mtab[j].y0)));
            end
            j = int'($urandom_range(0, NW - 1));
            rand_scan("rnd_scan", j);
        end

        do_scan("t6_reset", 472, 50, 10, -1, 0, none_w, -1, 10);
        chk_en("t6_layout_enable", 487, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
